// File: rtl/tick_timer.sv
// Synchronizes the divided slow clock, turns each of its rising edges into a
// one-cycle tick, and counts those ticks down in a loadable interval timer.
module tick_timer #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             slow_clk,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             clear,
   output logic             tick,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             paused,
   output logic             done,
   output logic             expired
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic                   tick_q, tick_d;
   logic [1:0]             state_q, state_d;
   logic [WIDTH-1:0]       count_q, count_d;
   logic                   expired_q, expired_d;
   logic                   rise;

   // SYNC_STAGES must be at least 2; stage 0 samples the asynchronous input.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], slow_clk};
      hist_d = sync_q[SYNC_STAGES-1];
      rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
      tick_d = rise;
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      expired_d = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         count_d = '0;
      end else if (start) begin
         if (load_val != '0) begin
            count_d = load_val;
            state_d = pause ? ST_PAUSED : ST_RUN;
         end else begin
            count_d   = '0;
            state_d   = ST_DONE;
            expired_d = 1'b1;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSED;
               end else if (rise) begin
                  if (count_q > WIDTH'(1)) begin
                     count_d = count_q - WIDTH'(1);
                  end else begin
                     count_d   = '0;
                     state_d   = ST_DONE;
                     expired_d = 1'b1;
                  end
               end
            end
            ST_PAUSED: begin
               if (!pause) state_d = ST_RUN;
            end
            ST_DONE:   count_d = '0;
            default:   count_d = '0;
         endcase
      end
   end

   // All-ones reset of the synchronizer and history keeps a slow_clk held
   // high across reset release from looking like a rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q    <= '1;
         hist_q    <= 1'b1;
         tick_q    <= 1'b0;
         state_q   <= ST_IDLE;
         count_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         hist_q    <= hist_d;
         tick_q    <= tick_d;
         state_q   <= state_d;
         count_q   <= count_d;
         expired_q <= expired_d;
      end
   end

   assign tick    = tick_q;
   assign count   = count_q;
   assign running = (state_q == ST_RUN);
   assign paused  = (state_q == ST_PAUSED);
   assign done    = (state_q == ST_DONE);
   assign expired = expired_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: tick generation, countdown, pause, zero load,
// control priority and asynchronous reset.
module tb_tick_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        slow_clk;
   logic [15:0] load_val;
   logic        start, pause, clear;
   logic        tick, running, paused, done, expired;
   logic [15:0] count;

   int checks   = 0;
   int failures = 0;
   logic tick_at, tick_after, exp_at, exp_after;

   tick_timer #(.WIDTH(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .slow_clk(slow_clk), .load_val(load_val),
      .start(start), .pause(pause), .clear(clear), .tick(tick),
      .count(count), .running(running), .paused(paused), .done(done),
      .expired(expired)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One slow period: rise sampled on E0, tick and count update on E2.
   task automatic do_tick();
      slow_clk = 1'b1;
      step(); step(); step();
      tick_at = tick;
      exp_at  = expired;
      slow_clk = 1'b0;
      step();
      tick_after = tick;
      exp_after  = expired;
      step(); step(); step();
   endtask

   initial begin
      int n_ticks, first_i, wide;
      logic prev;
      reset = 1'b1; slow_clk = 1'b1; load_val = '0;
      start = 1'b0; pause = 1'b0; clear = 1'b0;

      // Reset with slow_clk held high throughout
      step(); step(); step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_flags", {27'd0, tick, running, paused, done, expired}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("no_tick_after_rst", 32'(tick), 32'd0);
      end
      slow_clk = 1'b0;
      for (int i = 0; i < 5; i++) step();

      // 50-cycle square wave for 500 cycles
      n_ticks = 0; first_i = -1; wide = 0; prev = 1'b0;
      for (int i = 0; i < 500; i++) begin
         slow_clk = ((i % 50) < 25);
         step();
         if (tick) begin
            n_ticks++;
            if (first_i < 0) first_i = i;
            if (prev) wide++;
         end
         prev = tick;
      end
      chk("tick_total", 32'(n_ticks), 32'd10);
      chk("tick_first_idx", 32'(first_i), 32'd2);
      chk("tick_width", 32'(wide), 32'd0);
      chk("idle_ignores_ticks", {15'd0, count, running}, 32'd0);
      for (int i = 0; i < 4; i++) step();

      // Countdown from 5
      load_val = 16'd5; start = 1'b1;
      step();
      start = 1'b0;
      chk("cd_start_run", 32'(running), 32'd1);
      chk("cd_start_count", 32'(count), 32'd5);
      for (int k = 1; k <= 4; k++) begin
         do_tick();
         chk("cd_tick_pulse", {30'd0, tick_at, tick_after}, 32'd2);
         chk("cd_count", 32'(count), 32'(5 - k));
         chk("cd_running", 32'(running), 32'd1);
      end
      do_tick();
      chk("cd_final_count", 32'(count), 32'd0);
      chk("cd_done", {29'd0, done, running, paused}, 32'd4);
      chk("cd_expired_pulse", {30'd0, exp_at, exp_after}, 32'd2);

      // Pause after 2 ticks of a 4-tick interval
      clear = 1'b1; step(); clear = 1'b0;
      chk("clr_idle", {15'd0, count, done}, 32'd0);
      load_val = 16'd4; start = 1'b1; step(); start = 1'b0;
      do_tick(); do_tick();
      chk("ps_count_before", 32'(count), 32'd2);
      pause = 1'b1; step();
      chk("ps_paused", {30'd0, paused, running}, 32'd2);
      for (int k = 0; k < 3; k++) begin
         do_tick();
         chk("ps_hold", 32'(count), 32'd2);
         chk("ps_tick_still", 32'(tick_at), 32'd1);
      end
      pause = 1'b0; step();
      chk("ps_resume", {30'd0, running, paused}, 32'd2);
      do_tick();
      chk("ps_count_1", 32'(count), 32'd1);
      do_tick();
      chk("ps_done", {15'd0, count, done}, 32'd1);
      chk("ps_expired", 32'(exp_at), 32'd1);

      // Zero load, then restart from DONE
      load_val = 16'd0; start = 1'b1; step(); start = 1'b0;
      chk("zero_done", {29'd0, done, expired, running}, 32'd6);
      chk("zero_count", 32'(count), 32'd0);
      step();
      chk("zero_expired_1cyc", {30'd0, done, expired}, 32'd2);
      load_val = 16'd3; start = 1'b1; step(); start = 1'b0;
      chk("restart_run", {29'd0, running, done, paused}, 32'd4);
      chk("restart_count", 32'(count), 32'd3);

      // Clear beats start
      load_val = 16'd7; start = 1'b1; step();
      chk("pri_load7", 32'(count), 32'd7);
      load_val = 16'd2; clear = 1'b1; step();
      start = 1'b0; clear = 1'b0;
      chk("pri_clear_wins", {13'd0, count, running, paused, done}, 32'd0);

      // Start coincident with a rise discards that tick
      slow_clk = 1'b1; step(); step();
      load_val = 16'd2; start = 1'b1; step(); start = 1'b0;
      chk("pri_start_tick", 32'(tick), 32'd1);
      chk("pri_start_count", 32'(count), 32'd2);
      slow_clk = 1'b0;
      for (int i = 0; i < 4; i++) step();
      do_tick();
      chk("pri_next_tick", {15'd0, count, running}, 32'd3);

      // Asynchronous reset mid-count
      load_val = 16'd9; start = 1'b1; step(); start = 1'b0;
      chk("ar_count9", 32'(count), 32'd9);
      #2 reset = 1'b1;
      #1;
      chk("ar_count_now", 32'(count), 32'd0);
      chk("ar_flags_now", {27'd0, tick, running, paused, done, expired}, 32'd0);
      step();
      reset = 1'b0;
      step(); step();
      chk("ar_stays_idle", {14'd0, count, running, done}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
